// File: rtl/ex_mem_elastic_stage.sv
// ============================================================================
// Module  : ex_mem_elastic_stage
// Brief   : EX->MEM pipeline register with valid/ready handshake and 2-entry
//           skid buffer, sync flush, gated memory strobes and forwarding tap.
//           Optional stall counter enabled by defining EX_MEM_PERF_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_mem_elastic_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_W      = 5,
    parameter int MEM_CTRL_W = 3,
    parameter int WB_CTRL_W  = 2,
    parameter int WB_WE_BIT  = 1
) (
    input  logic                  reloj,
    input  logic                  reset_n,
    input  logic                  flush_EX,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [MEM_CTRL_W-1:0] ctrl_MEM_exe,
    input  logic [WB_CTRL_W-1:0]  ctrl_WB_exe,
    input  logic [DATA_W-1:0]     Y_ALU,
    input  logic [DATA_W-1:0]     DOB_exe,
    input  logic [REG_W-1:0]      Y_MUX,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  MEM_RD,
    output logic                  MEM_WR,
    output logic                  w_h,
    output logic [WB_CTRL_W-1:0]  ctrl_WB_mem,
    output logic [DATA_W-1:0]     DIR,
    output logic [DATA_W-1:0]     DI,
    output logic [REG_W-1:0]      Y_MUX_mem,
    output logic                  fwd_we,
    output logic [15:0]           stall_cnt
);

    localparam int ENT_W = MEM_CTRL_W + WB_CTRL_W + 2*DATA_W + REG_W;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nx;
    logic                  r_in_ready;
    logic [ENT_W-1:0]      r_head;
    logic [ENT_W-1:0]      r_skid;
    logic [ENT_W-1:0]      w_in_ent;
    logic                  w_accept;
    logic                  w_pop;
    logic                  w_load_h_in;
    logic                  w_load_h_skid;
    logic                  w_load_s;
    logic [MEM_CTRL_W-1:0] w_h_mem;
    logic [WB_CTRL_W-1:0]  w_h_wb;

    assign w_in_ent  = {ctrl_MEM_exe, ctrl_WB_exe, Y_ALU, DOB_exe, Y_MUX};
    assign out_valid = (r_state != ST_EMPTY);
    assign in_ready  = r_in_ready;
    assign w_accept  = in_valid & r_in_ready;
    assign w_pop     = out_valid & out_ready;

    always_comb begin
        w_state_nx    = r_state;
        w_load_h_in   = 1'b0;
        w_load_h_skid = 1'b0;
        w_load_s      = 1'b0;
        if (flush_EX) begin
            w_state_nx = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_state_nx  = ST_ONE;
                        w_load_h_in = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_pop) begin
                        w_load_h_in = 1'b1;
                    end else if (w_pop) begin
                        w_state_nx = ST_EMPTY;
                    end else if (w_accept) begin
                        w_state_nx = ST_FULL;
                        w_load_s   = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (w_pop) begin
                        w_state_nx    = ST_ONE;
                        w_load_h_skid = 1'b1;
                    end
                end
                default: w_state_nx = ST_EMPTY;
            endcase
        end
    end

    // Ready is derived from the next state so it is a clean flop output.
    always_ff @(posedge reloj or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nx;
            r_in_ready <= (w_state_nx != ST_FULL);
        end
    end

    always_ff @(posedge reloj or negedge reset_n) begin
        if (!reset_n) begin
            r_head <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_h_in) begin
                r_head <= w_in_ent;
            end else if (w_load_h_skid) begin
                r_head <= r_skid;
            end
            if (w_load_s) begin
                r_skid <= w_in_ent;
            end
        end
    end

    assign {w_h_mem, w_h_wb, DIR, DI, Y_MUX_mem} = r_head;

    // Strobes are masked so a bubble never writes memory or the register file.
    assign MEM_RD      = out_valid & w_h_mem[2];
    assign MEM_WR      = out_valid & w_h_mem[1];
    assign w_h         = out_valid & w_h_mem[0];
    assign ctrl_WB_mem = out_valid ? w_h_wb : '0;
    assign fwd_we      = out_valid & w_h_wb[WB_WE_BIT];

`ifdef EX_MEM_PERF_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge reloj or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cnt <= 16'h0000;
        end else if (out_valid && !out_ready && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'h0001;
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = 16'h0000;
`endif

endmodule

`default_nettype wire
